// File: rtl/timer_pkg.sv
// Shared types and defaults for the timing/sequencing counter blocks.
package timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : timer_pkg

// File: rtl/dec_n.sv
// Combinational WIDTH-bit decrementer: ripple adder of the operand with all-ones.
// borrow_n is the adder carry-out, high whenever a != 0 (no borrow taken).
module dec_n
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             borrow_n
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH:0] carry;

  // Full-adder chain with b tied to ONES and carry-in of zero.
  always_comb begin
    carry = '0;
    y     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      y[i]         = a[i] ^ ONES[i] ^ carry[i];
      carry[i + 1] = (a[i] & ONES[i]) | (a[i] & carry[i]) | (ONES[i] & carry[i]);
    end
    borrow_n = carry[WIDTH];
  end

endmodule : dec_n

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle registered done pulse on expiry.
// Define COUNTDOWN_TIMER_AUTO_RELOAD_EN to reload from the start value and run periodically.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dec_y;
  logic             dec_nz;
  logic             expire_c;

  dec_n #(.WIDTH(WIDTH)) u_dec (
    .a        (out_q),
    .y        (dec_y),
    .borrow_n (dec_nz)
  );

  // out_q == 1 exactly when the decrement result is zero without a borrow.
  assign expire_c = dec_nz && (dec_y == '0);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Next state: load beats abort beats counting; idle never decrements.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      out_d   = load_val;
      state_d = (load_val != '0) ? RUN : IDLE;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
    end else if (abort) begin
      state_d = IDLE;
    end else if ((state_q == RUN) && en) begin
      if (expire_c) begin
        done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        out_d  = reload_q;
`else
        out_d   = dec_y;
        state_d = IDLE;
`endif
      end else begin
        out_d = dec_y;
      end
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (WIDTH=8).
module tb_countdown_timer;

  localparam int unsigned W = 8;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         abort;
  logic [W-1:0] out;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int eo, input int eb, input int ed);
    check({tag, ".out"},  32'(out),  32'(eo));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; abort = 1'b0;
    #3;
    chk3("reset_hold", 0, 0, 0);
    tick; tick;
    rst = 1'b0;
    chk3("after_reset", 0, 0, 0);

    // Load 5, count with en held high.
    load = 1'b1; load_val = 8'd5; en = 1'b1;
    tick;
    load = 1'b0;
    chk3("t1_load", 5, 1, 0);
    for (int k = 4; k >= 1; k--) begin
      tick;
      chk3("t1_count", k, 1, 0);
    end
    tick;
    chk3("t1_expire", AR ? 5 : 0, AR ? 1 : 0, 1);
    abort = 1'b1; tick; abort = 1'b0;
    chk3("t1_stop", AR ? 5 : 0, 0, 0);
    tick;
    chk3("t1_idle_nowrap", AR ? 5 : 0, 0, 0);

    // Load 4, en alternating 0/1 after the load edge.
    load = 1'b1; load_val = 8'd4; en = 1'b1;
    tick;
    load = 1'b0;
    chk3("t2_load", 4, 1, 0);
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 1);
      tick;
      if (i == 7) chk3("t2_expire", AR ? 4 : 0, AR ? 1 : 0, 1);
      else        chk3("t2_count", 4 - (i + 1) / 2, 1, 0);
    end
    abort = 1'b1; en = 1'b0; tick; abort = 1'b0;
    chk3("t2_stop", AR ? 4 : 0, 0, 0);

    // Load 0 stays idle; load 1 expires on the next edge.
    load = 1'b1; load_val = 8'd0; en = 1'b1;
    tick;
    load = 1'b0;
    chk3("t3_load0", 0, 0, 0);
    tick;
    chk3("t3_load0_hold", 0, 0, 0);
    load = 1'b1; load_val = 8'd1;
    tick;
    load = 1'b0;
    chk3("t3_load1", 1, 1, 0);
    tick;
    chk3("t3_load1_expire", AR ? 1 : 0, AR ? 1 : 0, 1);
    abort = 1'b1; tick; abort = 1'b0;
    chk3("t3_stop", AR ? 1 : 0, 0, 0);

    // Reload during RUN restarts the count with no done for the old one.
    load = 1'b1; load_val = 8'd10; en = 1'b1;
    tick;
    load = 1'b0;
    for (int k = 9; k >= 6; k--) begin
      tick;
      chk3("t4_count10", k, 1, 0);
    end
    load = 1'b1; load_val = 8'd3;
    tick;
    load = 1'b0;
    chk3("t4_reload", 3, 1, 0);
    tick; chk3("t4_count3", 2, 1, 0);
    tick; chk3("t4_count3", 1, 1, 0);
    tick; chk3("t4_expire", AR ? 3 : 0, AR ? 1 : 0, 1);
    abort = 1'b1; tick; abort = 1'b0;
    chk3("t4_stop", AR ? 3 : 0, 0, 0);

    // Abort at 7 holds the count and goes idle.
    load = 1'b1; load_val = 8'd10; en = 1'b1;
    tick;
    load = 1'b0;
    tick; tick; tick;
    chk3("t5_pre_abort", 7, 1, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk3("t5_abort", 7, 0, 0);
    tick;
    chk3("t5_idle_hold", 7, 0, 0);

    // Load wins over abort; en=0 holds in RUN.
    load = 1'b1; abort = 1'b1; load_val = 8'd5;
    tick;
    load = 1'b0; abort = 1'b0; en = 1'b0;
    chk3("t6_load_over_abort", 5, 1, 0);
    tick;
    chk3("t6_en0_hold", 5, 1, 0);

    // Asynchronous reset mid-count at 0x37.
    load = 1'b1; load_val = 8'h37;
    tick;
    load = 1'b0;
    chk3("t7_load37", 8'h37, 1, 0);
    #2 rst = 1'b1;
    #1 chk3("t7_async_rst", 0, 0, 0);
    tick;
    rst = 1'b0;
    chk3("t7_after_rst", 0, 0, 0);

    // Reset while done is high drops the pulse immediately.
    load = 1'b1; load_val = 8'd1; en = 1'b1;
    tick;
    load = 1'b0;
    tick;
    chk3("t8_done_high", AR ? 1 : 0, AR ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1 chk3("t8_done_lost", 0, 0, 0);
    tick;
    rst = 1'b0;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // Periodic reload of 3 over 9 enabled cycles.
    load = 1'b1; load_val = 8'd3; en = 1'b1;
    tick;
    load = 1'b0;
    chk3("ar_load3", 3, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      tick;
      chk3("ar_period3", (k % 3 == 0) ? 3 : 3 - (k % 3), 1, (k % 3 == 0) ? 1 : 0);
    end
    // Reload of 1 pulses done on every enabled cycle.
    load = 1'b1; load_val = 8'd1;
    tick;
    load = 1'b0;
    chk3("ar_load1", 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk3("ar_period1", 1, 1, 1);
    end
    abort = 1'b1; tick; abort = 1'b0;
    chk3("ar_abort", 1, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_countdown_timer
